// File: rtl/alu_logic_pkg.sv
// Shared definitions for the ALU bitwise logic path: opcode encodings and
// a width-agnostic evaluation function used by the datapath.
package alu_logic_pkg;

    localparam int LOGIC_OP_W  = 3;
    localparam int LOGIC_MAX_W = 64;

    localparam logic [LOGIC_OP_W-1:0] OP_AND  = 3'd0;
    localparam logic [LOGIC_OP_W-1:0] OP_OR   = 3'd1;
    localparam logic [LOGIC_OP_W-1:0] OP_XOR  = 3'd2;
    localparam logic [LOGIC_OP_W-1:0] OP_NOR  = 3'd3;
    localparam logic [LOGIC_OP_W-1:0] OP_NAND = 3'd4;
    localparam logic [LOGIC_OP_W-1:0] OP_XNOR = 3'd5;
    localparam logic [LOGIC_OP_W-1:0] OP_ANDN = 3'd6;
    localparam logic [LOGIC_OP_W-1:0] OP_PASS = 3'd7;

    // Evaluated at the maximum width; callers keep the low WIDTH bits.
    function automatic logic [LOGIC_MAX_W-1:0] logic_eval(
        input logic [LOGIC_OP_W-1:0]  op,
        input logic [LOGIC_MAX_W-1:0] x,
        input logic [LOGIC_MAX_W-1:0] y
    );
        logic [LOGIC_MAX_W-1:0] r;
        case (op)
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_XOR:  r = x ^ y;
            OP_NOR:  r = ~(x | y);
            OP_NAND: r = ~(x & y);
            OP_XNOR: r = ~(x ^ y);
            OP_ANDN: r = x & ~y;
            default: r = x;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_pipe_slice.sv
// One valid/ready register slice. Ready is combinational from downstream so a
// chain of slices sustains one transfer per cycle with no bubbles.
module logic_pipe_slice #(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload
);

    logic                 r_valid;
    logic [PAYLOAD_W-1:0] r_payload;

    assign in_ready    = !r_valid || out_ready;
    assign out_valid   = r_valid;
    assign out_payload = r_payload;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_payload <= '0;
        end else if (in_ready) begin
            r_valid <= in_valid;
            // Payload only moves with a real transaction so idle cycles keep it.
            if (in_valid) begin
                r_payload <= in_payload;
            end
        end
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined eight-function bitwise logic unit with zero/all-ones flags and a
// passthrough tag; result is computed before stage 0, later stages only carry it.
module logic_unit_pipe
    import alu_logic_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LOGIC_OP_W-1:0] in_op,
    input  logic [WIDTH-1:0]      in_x,
    input  logic [WIDTH-1:0]      in_y,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_z,
    output logic                  out_zero,
    output logic                  out_ones,
    output logic [TAG_W-1:0]      out_tag
);

    localparam int PAYLOAD_W = WIDTH + 2 + TAG_W;
    localparam logic [LOGIC_MAX_W-1:0] W_MASK = {LOGIC_MAX_W{1'b1}} >> (LOGIC_MAX_W - WIDTH);

    logic [LOGIC_MAX_W-1:0] w_x_ext;
    logic [LOGIC_MAX_W-1:0] w_y_ext;
    logic [LOGIC_MAX_W-1:0] w_eval;
    logic                   w_zero;
    logic                   w_ones;

    logic                 w_valid   [0:STAGES];
    logic                 w_ready   [0:STAGES];
    logic [PAYLOAD_W-1:0] w_payload [0:STAGES];

    assign w_x_ext = LOGIC_MAX_W'(in_x);
    assign w_y_ext = LOGIC_MAX_W'(in_y);
    assign w_eval  = logic_eval(in_op, w_x_ext, w_y_ext);

    // Flags look only at the live WIDTH bits; bits above WIDTH are masked out.
    assign w_zero = ~|(w_eval & W_MASK);
    assign w_ones = &(w_eval | ~W_MASK);

    assign w_valid[0]      = in_valid;
    assign w_payload[0]    = {w_eval[WIDTH-1:0], w_zero, w_ones, in_tag};
    assign in_ready        = w_ready[0];
    assign w_ready[STAGES] = out_ready;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic_pipe_slice #(
            .PAYLOAD_W(PAYLOAD_W)
        ) u_slice (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (w_valid[gi]),
            .in_ready   (w_ready[gi]),
            .in_payload (w_payload[gi]),
            .out_valid  (w_valid[gi+1]),
            .out_ready  (w_ready[gi+1]),
            .out_payload(w_payload[gi+1])
        );
    end

    assign out_valid = w_valid[STAGES];
    assign {out_z, out_zero, out_ones, out_tag} = w_payload[STAGES];

endmodule
